// File: rtl/iot_feeder.sv
// iot_feeder: byte-stream framing stage in front of the IoT data-filter core.
// Source bytes enter a DEPTH-byte FIFO through a valid/ready handshake. They
// leave as bursts of exactly WORD_BYTES bytes on in_en/iot_in. A burst starts
// only once a whole word is buffered, and it pauses while the core asserts busy.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   src_valid/data   source byte handshake (input side)
//   src_ready        combinational: FIFO not full
//   busy             back-pressure from the filter core
//   in_en, iot_in    registered byte strobe and byte to the core
//   word_idx         registered index of the current/last word in the round
//   round_done       registered pulse after the last byte of the round
//
// Optional feature: define IOT_FEEDER_STATS_EN to add the words_sent and
// stall_cycles saturating counters as output ports.
module iot_feeder #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WORD_BYTES  = 16,
  parameter int unsigned ROUND_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  input  logic        busy,
  output logic        in_en,
  output logic [7:0]  iot_in,
  output logic [2:0]  word_idx,
  output logic        round_done
`ifdef IOT_FEEDER_STATS_EN
  ,
  output logic [15:0] words_sent,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = 4;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic               word_end_q, word_end_d;
  logic               in_en_q, in_en_d;
  logic [7:0]         iot_in_q, iot_in_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               round_done_q, round_done_d;

  logic full_c;
  logic push_c;
  logic pop_c;
  logic last_c;

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens the input.
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign src_ready = !full_c;
  assign push_c    = src_valid && !full_c;

  // Burst sequencing: decides when to pop and tracks the byte position.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pop_c      = 1'b0;
    last_c     = 1'b0;
    case (state_q)
      IDLE: begin
        // word_end_q blocks a start right after a word, leaving one idle
        // cycle on in_en between consecutive words.
        if (!word_end_q && (count_q >= CNT_W'(WORD_BYTES)) && !busy) begin
          pop_c      = 1'b1;
          byte_cnt_d = BCNT_W'(1);
          state_d    = BURST;
        end
      end
      BURST, HOLD: begin
        if (busy) begin
          state_d = HOLD;
        end else begin
          pop_c = 1'b1;
          if (byte_cnt_q == BCNT_W'(WORD_BYTES - 1)) begin
            last_c     = 1'b1;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            state_d    = BURST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, occupancy and output datapath.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    in_en_d      = pop_c;
    iot_in_d     = iot_in_q;
    word_end_d   = last_c;
    word_idx_d   = word_idx_q;
    round_done_d = 1'b0;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      iot_in_d = mem_q[rd_ptr_q];
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // word_end_q is high while the last byte of a word is on iot_in.
    if (word_end_q) begin
      if (word_idx_q == IDX_W'(ROUND_WORDS - 1)) begin
        word_idx_d   = '0;
        round_done_d = 1'b1;
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
      end
    end
  end

  // Byte storage; contents need no reset because the pointers and count do.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      word_end_q   <= 1'b0;
      in_en_q      <= 1'b0;
      iot_in_q     <= '0;
      word_idx_q   <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      byte_cnt_q   <= byte_cnt_d;
      word_end_q   <= word_end_d;
      in_en_q      <= in_en_d;
      iot_in_q     <= iot_in_d;
      word_idx_q   <= word_idx_d;
      round_done_q <= round_done_d;
    end
  end

  assign in_en      = in_en_q;
  assign iot_in     = iot_in_q;
  assign word_idx   = word_idx_q;
  assign round_done = round_done_q;

`ifdef IOT_FEEDER_STATS_EN
  logic [15:0] words_sent_q, words_sent_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Saturating statistics counters.
  always_comb begin
    words_sent_d   = words_sent_q;
    stall_cycles_d = stall_cycles_q;
    if (word_end_q && (words_sent_q != '1))
      words_sent_d = words_sent_q + 16'(1);
    if ((state_q == HOLD) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 16'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      words_sent_q   <= words_sent_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign words_sent   = words_sent_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_iot_feeder.sv
// Testbench for iot_feeder. Bytes accepted at the source go into a scoreboard
// queue, and a negedge monitor pops the queue for every in_en byte. Directed
// phases check timing, pause, full, round and reset behaviour. A random phase
// then checks the word and round totals derived from the number of bytes sent.
module tb_iot_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'h00;
  logic        src_ready;
  logic        busy = 1'b0;
  logic        in_en;
  logic [7:0]  iot_in;
  logic [2:0]  word_idx;
  logic        round_done;
`ifdef IOT_FEEDER_STATS_EN
  logic [15:0] words_sent;
  logic [15:0] stall_cycles;
`endif

  iot_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .busy       (busy),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .word_idx   (word_idx),
    .round_done (round_done)
`ifdef IOT_FEEDER_STATS_EN
    ,
    .words_sent   (words_sent),
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sb[$];
  int         en_cyc[$];
  int         rd_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         n_pushed = 0;
  int         last_p = 0;
  int         stall_exp = 0;
  logic [7:0] mexp;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int en_at(input int i);
    if (i < en_cyc.size()) return en_cyc[i];
    return -1;
  endfunction

  // Monitor: every byte the DUT presents must be the oldest unsent byte.
  always @(negedge clk) begin
    if (rst_n && in_en) begin
      en_cyc.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL data: byte %0h presented with nothing outstanding", iot_in);
      end else begin
        mexp = sb.pop_front();
        if (iot_in !== mexp) begin
          bad++;
          $display("FAIL data: got %0h expected %0h at cycle %0d", iot_in, mexp, cyc);
        end
      end
    end
    if (rst_n && round_done) rd_cyc.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    for (int k = 0; k < 200 && cyc < c; k++) tick(1);
  endtask

  // Present one byte until accepted (bounded); last_p is the presenting cycle.
  task automatic push_byte(input logic [7:0] b);
    bit acc;
    int p;
    acc = 1'b0;
    p = 0;
    for (int k = 0; k < 64 && !acc; k++) begin
      src_valid = 1'b1;
      src_data  = b;
      p = cyc;
      @(negedge clk);
      acc = src_ready;
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
    if (acc) begin
      sb.push_back(b);
      n_pushed++;
      last_p = p;
    end else begin
      total++;
      bad++;
      $display("FAIL push_timeout: byte %0h never accepted", b);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_in_en"}, int'(in_en), 0);
    chk({tag, "_iot_in"}, int'(iot_in), 0);
    chk({tag, "_word_idx"}, int'(word_idx), 0);
    chk({tag, "_round_done"}, int'(round_done), 0);
    chk({tag, "_src_ready"}, int'(src_ready), 1);
`ifdef IOT_FEEDER_STATS_EN
    chk({tag, "_words_sent"}, int'(words_sent), 0);
    chk({tag, "_stall_cycles"}, int'(stall_cycles), 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int c;
    int words;
    bit acc;

    // Reset values
    tick(3);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_src_ready", int'(src_ready), 1);

    // One word back-to-back: 16 consecutive bytes starting 2 cycles later
    en_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    p = last_p;
    tick(22);
    chk("t1_count", en_cyc.size(), 16);
    chk("t1_first", en_at(0), p + 2);
    chk("t1_last", en_at(15), p + 17);
    chk("t1_word_idx", int'(word_idx), 1);

    // 15 bytes never start a burst; the 16th does
    en_cyc.delete();
    for (int i = 0; i < 15; i++) push_byte(8'($urandom));
    tick(50);
    chk("t2_no_burst", en_cyc.size(), 0);
    push_byte(8'($urandom));
    p = last_p;
    tick(22);
    chk("t2_count", en_cyc.size(), 16);
    chk("t2_first", en_at(0), p + 2);
    chk("t2_word_idx", int'(word_idx), 2);

    // busy for 3 cycles from the cycle byte 5 is driven
    en_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    p = last_p;
    c = p + 7;
    wait_until(c);
    busy = 1'b1;
    tick(3);
    busy = 1'b0;
    stall_exp += 3;
    tick(25);
    chk("t3_count", en_cyc.size(), 16);
    chk("t3_byte5", en_at(5), c);
    chk("t3_byte6", en_at(6), c + 4);
    chk("t3_byte15", en_at(15), c + 13);
    chk("t3_word_idx", int'(word_idx), 3);

    // Fill to DEPTH while busy, then release: two words with one idle cycle
    en_cyc.delete();
    busy = 1'b1;
    for (int i = 0; i < 32; i++) push_byte(8'($urandom));
    @(negedge clk);
    chk("t4_full_ready", int'(src_ready), 0);
    @(posedge clk);
    #1;
    src_valid = 1'b1;
    src_data  = 8'hEE;
    @(negedge clk);
    chk("t4_extra_ready", int'(src_ready), 0);
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    busy = 1'b0;
    tick(45);
    chk("t4_count", en_cyc.size(), 32);
    chk("t4_word0_span", en_at(15) - en_at(0), 15);
    chk("t4_gap", en_at(16) - en_at(15), 2);
    chk("t4_word1_span", en_at(31) - en_at(16), 15);
    chk("t4_word_idx", int'(word_idx), 5);

    // Three more words complete the round of 8
    en_cyc.delete();
    rd_cyc.delete();
    for (int i = 0; i < 48; i++) push_byte(8'($urandom));
    tick(60);
    chk("t5_count", en_cyc.size(), 48);
    chk("t5_round_pulses", rd_cyc.size(), 1);
    if (rd_cyc.size() > 0)
      chk("t5_round_time", rd_cyc[0], en_at(47) + 1);
    chk("t5_word_idx", int'(word_idx), 0);
`ifdef IOT_FEEDER_STATS_EN
    chk("t5_words_sent", int'(words_sent), 8);
    chk("t5_stall_cycles", int'(stall_cycles), stall_exp);
`endif

    // Reset while byte 9 is on iot_in
    en_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    p = last_p;
    wait_until(p + 11);
    rst_n = 1'b0;
    sb.delete();
    rd_cyc.delete();
    n_pushed = 0;
    stall_exp = 0;
    chk("t6_bytes_before_reset", en_cyc.size(), 9);
    chk_reset_outputs("t6_in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("t6_src_ready", int'(src_ready), 1);
    en_cyc.delete();
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    p = last_p;
    tick(22);
    chk("t6_count", en_cyc.size(), 16);
    chk("t6_first", en_at(0), p + 2);
    chk("t6_word_idx", int'(word_idx), 1);

    // Random traffic with random back-pressure, then drain
    for (int i = 0; i < 900; i++) begin
      src_valid = ($urandom_range(0, 9) < 7);
      src_data  = 8'($urandom);
      busy      = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      acc = src_valid && src_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sb.push_back(src_data);
        n_pushed++;
      end
    end
    src_valid = 1'b0;
    busy = 1'b0;
    tick(80);
    words = n_pushed / 16;
    chk("rnd_left_in_fifo", sb.size(), n_pushed % 16);
    chk("rnd_word_idx", int'(word_idx), words % 8);
    chk("rnd_round_pulses", rd_cyc.size(), words / 8);
`ifdef IOT_FEEDER_STATS_EN
    chk("rnd_words_sent", int'(words_sent), words);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iot_feeder.md
# iot_feeder

Upstream framing stage for the IoT data-filter core. Accepts a byte stream from the sensor interface through a valid/ready handshake, buffers it in a small FIFO, and drives the filter core's `in_en`/`iot_in` port in bursts of exactly one 128-bit word (16 bytes). Bursts start only when a full word is buffered, so the core never sees a partial word. A burst pauses whenever the core raises `busy`.

## Interface
- `DEPTH`, 32: FIFO depth in bytes; power of two, ≥ 16.
- `WORD_BYTES`, 16: bytes per burst; fixed at 16 for the current core.
- `ROUND_WORDS`, 8: words per processing round; used for `round_done`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_valid` in 1: a source byte is presented.
- `src_data` in 8: source byte.
- `src_ready` out 1: the FIFO can accept a byte. Combinational: `!full`.
- `busy` in 1: back-pressure from the filter core.
- `in_en` out 1: registered; the byte on `iot_in` is valid this cycle.
- `iot_in` out 8: registered byte to the core.
- `word_idx` out 3: registered; index of the word currently or last sent within the round (0..ROUND_WORDS-1).
- `round_done` out 1: registered one-cycle pulse on the cycle after the last byte of word ROUND_WORDS-1.

## Operation
- FIFO:
  - Circular buffer of DEPTH bytes with a $clog2(DEPTH)+1-bit occupancy count.
  - Push occurs when `src_valid && src_ready`.
  - Pop occurs when the FSM issues a byte.
  - A push and a pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Full behaviour: `src_ready` is 0 when count == DEPTH, even if a pop happens in the same cycle. Overflow is impossible by construction.
- FSM states: IDLE, BURST, HOLD.
  - IDLE → BURST when count ≥ WORD_BYTES and `!busy`. The first byte is popped in this same cycle.
  - BURST: one byte is popped per cycle while `!busy`.
    - After the 16th pop (byte counter 15), go to IDLE.
    - If `busy` is high, go to HOLD without popping.
  - HOLD: no pop and the byte counter is held. Return to BURST when `!busy`; the pop occurs in that cycle.
- Byte order: the first byte pushed is the first byte driven. Byte ordering within the word is the core's responsibility.
- Back-to-back bursts: if 16+ bytes remain at the end of a burst and `!busy`, a new burst starts on the next cycle. There is exactly one idle cycle (`in_en` = 0) between words, which gives the core word-boundary alignment.
- Counters:
  - The 4-bit byte counter resets to 0 at each burst start.
  - `word_idx` increments after each completed word and wraps ROUND_WORDS-1 → 0. At that wrap, `round_done` pulses.

## Timing
- Reset values: `in_en` = 0, `iot_in` = 0, `word_idx` = 0, `round_done` = 0. The FIFO is empty, so `src_ready` = 1 once `rst_n` is high. FSM is in IDLE.
- Assertion of `rst_n` low mid-burst discards all buffered bytes and the partial word immediately; there is no flush handshake.
- Pop at cycle t ⇒ `in_en` = 1 and `iot_in` = that byte during cycle t+1.
- `busy` sampled high at cycle t ⇒ no pop at t ⇒ `in_en` = 0 at t+1. Latency from `busy` to pause is one cycle.
- Minimum latency from the 16th byte accepted to the first `in_en`: 2 cycles (push at t, pop at t+1, `in_en` at t+2).
- Sustained throughput: 16 bytes per 17 cycles when the source is unthrottled and `busy` is low.

## Configuration
- `IOT_FEEDER_STATS_EN`: when defined, adds two ports.
  - `words_sent` out 16: registered, saturating count of completed words since reset.
  - `stall_cycles` out 16: saturating count of cycles spent in HOLD.
  - Both reset to 0.
- Without the macro, neither port nor its counter exists; all other behaviour is identical.

## Test plan
- Reset, then push bytes 0x00..0x0F back-to-back with `busy` = 0 → `in_en` high for exactly 16 consecutive cycles, starting 2 cycles after byte 0x0F is pushed. `iot_in` = 0x00..0x0F in order. `word_idx` goes 0 → 1 after the burst.
- Push 15 bytes and wait 50 cycles → `in_en` never asserts. Push the 16th byte → the burst starts 2 cycles later.
- Run a burst and hold `busy` = 1 for 3 cycles after byte 5 is driven → `in_en` low for exactly 3 cycles. Bytes 6..15 follow with no loss or duplication.
- Fill the FIFO to DEPTH = 32 with `busy` = 1 → `src_ready` = 0, and a further `src_valid` is not accepted. Release `busy` → 2 words are emitted with one idle cycle between them, in order. The pointer wrap is exercised by pushing 64 bytes total.
- Send 8 words → `round_done` pulses for one cycle after the last byte of word 7. `word_idx` returns to 0. With `IOT_FEEDER_STATS_EN`: `words_sent` = 8, and `stall_cycles` matches the total `busy`-held cycles.
- Assert `rst_n` low mid-burst at byte 9 → outputs return to reset values and the FIFO is empty. After release, a fresh 16-byte word is emitted correctly.
